instr_fetch: RTL

Instruction fetch stage sitting directly upstream of `simple_cpu`. It holds a 32-entry program store, maintains the program counter, and presents one 20-bit instruction at a time on a valid/ready handshake. The instruction is held stable until the CPU accepts it. A program is loaded through a write port while the block is idle or halted. Fetch stops on a HALT opcode.

---
 rtl/instr_fetch_if.sv | 26 ++
 rtl/instr_fetch.sv | 95 +++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus between instr_fetch and its surroundings: control, program load
// port and the instruction valid/ready handshake towards the CPU.
interface instr_fetch_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   start;
    logic                   load_we;
    logic [PC_BITS-1:0]     load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   instr_ready;
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instruction;
    logic [PC_BITS-1:0]     pc;
    logic                   halted;

    modport master (
        input  start, load_we, load_addr, load_data, instr_ready,
        output instr_valid, instruction, pc, halted
    );

    modport slave (
        output start, load_we, load_addr, load_data, instr_ready,
        input  instr_valid, instruction, pc, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program store, PC and a held valid/ready issue port.
// Optional macro IFETCH_WRAP_EN: PC wraps to 0 after the last address instead of halting.
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_if.master     bus
);
    localparam int DEPTH = 1 << PC_BITS;
    localparam logic [PC_BITS-1:0] PC_LAST = {PC_BITS{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

    state_t                 r_state;
    logic [PC_BITS-1:0]     r_pc;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_valid;
    logic                   r_halted;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

    logic [INSTR_WIDTH-1:0] w_rd_data;
    logic                   w_rd_is_halt;
    logic                   w_load_ok;

    assign w_rd_data    = r_mem[r_pc];
    assign w_rd_is_halt = (w_rd_data[INSTR_WIDTH-1 -: 2] == 2'b00);
    assign w_load_ok    = bus.load_we && ((r_state == S_IDLE) || (r_state == S_HALT));

    // Store is deliberately not reset; writes land before a same-cycle start's FETCH read.
    always_ff @(posedge clk) begin
        if (w_load_ok)
            r_mem[bus.load_addr] <= bus.load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_instr <= w_rd_data;
                    if (w_rd_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_valid && bus.instr_ready) begin
                        r_valid <= 1'b0;
                        if (r_pc == PC_LAST) begin
`ifdef IFETCH_WRAP_EN
                            r_pc    <= '0;
                            r_state <= S_FETCH;
`else
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
`endif
                        end else begin
                            r_pc    <= r_pc + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (bus.start) begin
                        r_halted <= 1'b0;
                        r_pc     <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_valid = r_valid;
    assign bus.instruction = r_instr;
    assign bus.pc          = r_pc;
    assign bus.halted      = r_halted;
endmodule
